// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and queue entry type for the fetch stage.
// Optional misaligned-redirect trap is enabled with IF_MISALIGN_TRAP_EN.
package fetch_pkg;
  localparam int ILEN = 32;
  localparam int FETCH_STRIDE = 4;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misalign;
  } fq_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with flush and occupancy count.
// A push in a flush cycle lands in the freshly emptied FIFO.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, wr_idx;
  logic do_pop, we;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign we = push &&
    (flush || count != CW'(DEPTH) || do_pop);
  assign wr_idx = flush ? '0 : wr_ptr;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= we ? inc('0) : '0;
      count  <= we ? CW'(1) : '0;
    end else begin
      if (do_pop) rd_ptr <= inc(rd_ptr);
      if (we) wr_ptr <= inc(wr_ptr);
      count <= count + CW'(we) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wdata;
  end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential prefetcher with credit-limited queue.
// IF_MISALIGN_TRAP_EN adds if_misalign and traps unaligned redirects.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] branch_result,
  input  logic            was_branch,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_propagation
`ifdef IF_MISALIGN_TRAP_EN
  ,output logic           if_misalign
`endif
);
`ifdef IF_MISALIGN_TRAP_EN
  localparam int EW = 2 * XLEN + 1;
`else
  localparam int EW = 2 * XLEN;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] pc, target, tag_pc;
  logic [OW-1:0] inflight, drop_cnt, live;
  logic [CW-1:0] iq_count;
  logic [EW-1:0] iq_wdata, iq_rdata, head_q, head;
  logic iq_push, iq_pop, iq_empty;
  logic accept, credit, bad_tgt, halted;

`ifdef IF_MISALIGN_TRAP_EN
  assign target = branch_result;
  assign bad_tgt = was_branch && (branch_result[1:0] != 2'b00);
  assign iq_wdata = bad_tgt
    ? {target, {XLEN{1'b0}}, 1'b1}
    : {tag_pc, imem_resp_data, 1'b0};
  assign if_misalign = head[0];

  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else if (was_branch) halted <= bad_tgt;
  end
`else
  assign target = branch_result & ~XLEN'(3);
  assign bad_tgt = 1'b0;
  assign halted = 1'b0;
  assign iq_wdata = {tag_pc, imem_resp_data};
`endif

  // Stale responses still occupy inflight but hold no queue credit
  assign live = inflight - drop_cnt;
  assign credit = was_branch ||
    (int'(iq_count) + int'(live) < DEPTH);
  assign imem_req_valid = !rst && !bad_tgt &&
    (!halted || was_branch) && credit &&
    (int'(inflight) < MAX_OUTSTANDING);
  assign imem_req_addr = was_branch ? target : pc;
  assign accept = imem_req_valid && imem_req_ready;

  assign iq_empty = (iq_count == '0);
  assign if_valid = !iq_empty;
  assign iq_pop = if_valid && id_ready;
  assign iq_push = bad_tgt || (imem_resp_valid &&
    drop_cnt == '0 && !was_branch);

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_iq (
    .clk  (clk),
    .rst  (rst),
    .flush(was_branch),
    .push (iq_push),
    .wdata(iq_wdata),
    .pop  (iq_pop),
    .rdata(iq_rdata),
    .count(iq_count)
  );

  // One tag per accepted request; its count is the inflight total
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag (
    .clk  (clk),
    .rst  (rst),
    .flush(1'b0),
    .push (accept),
    .wdata(imem_req_addr),
    .pop  (imem_resp_valid),
    .rdata(tag_pc),
    .count(inflight)
  );

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else if (accept) pc <= imem_req_addr + XLEN'(FETCH_STRIDE);
    else if (was_branch) pc <= target;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (was_branch)
      drop_cnt <= inflight - OW'(imem_resp_valid);
    else if (imem_resp_valid && drop_cnt != '0)
      drop_cnt <= drop_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) head_q <= '0;
    else if (!iq_empty) head_q <= iq_rdata;
  end

  assign head = iq_empty ? head_q : iq_rdata;
  assign pc_propagation = head[EW-1 -: XLEN];
  assign instr_out = head[EW-XLEN-1 -: XLEN];
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: scoreboard bench with an in-order memory model.
// Build with IF_MISALIGN_TRAP_EN defined to exercise the trap path.
module tb_fetch_prefetch_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [XLEN-1:0] branch_result = '0;
  logic was_branch = 1'b0;
  logic imem_req_valid;
  logic imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic imem_resp_valid = 1'b0;
  logic [XLEN-1:0] imem_resp_data = '0;
  logic if_valid;
  logic id_ready = 1'b0;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] pc_propagation;
`ifdef IF_MISALIGN_TRAP_EN
  logic if_misalign;
`endif

  fetch_prefetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .RESET_PC('0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_result  (branch_result),
    .was_branch     (was_branch),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .instr_out      (instr_out),
    .pc_propagation (pc_propagation)
`ifdef IF_MISALIGN_TRAP_EN
    ,.if_misalign   (if_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int due;
    int ep;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic mis;
  } exp_t;

  mreq_t memq[$];
  exp_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int epoch = 0;
  int lat = 1;
  int pops = 0;
  int first_acc = -1;
  int first_val = -1;
  logic [31:0] exp_next = '0;
  logic [31:0] last_pc = '0;
  logic halted_m = 1'b0;
  logic s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_pc;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; was_branch = 1'b0; branch_result = '0;
    imem_req_ready = 1'b0; id_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(posedge clk); #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_instr", instr_out, 0);
    check("rst_pc", pc_propagation, 0);
    rst = 1'b0;
    memq.delete(); expq.delete();
    epoch++; exp_next = '0; halted_m = 1'b0;
    first_acc = -1; first_val = -1;
  endtask

  task automatic step(input logic wb, input logic [31:0] tgt,
                      input logic rr, input logic idr);
    mreq_t m;
    exp_t e;
    int n_out, n_live;
    logic [31:0] t;
    logic mis_t, rv, exp_rv;
    @(posedge clk); #1;
    cyc++;
    n_out = memq.size();
    n_live = 0;
    foreach (memq[i]) if (memq[i].ep == epoch) n_live++;
    was_branch = wb; branch_result = tgt;
    imem_req_ready = rr; id_ready = idr;
    imem_resp_valid = 1'b0; imem_resp_data = '0; rv = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      rv = 1'b1;
      imem_resp_valid = 1'b1;
      imem_resp_data = m.data;
    end
    #1;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_if_valid = if_valid; s_pc = pc_propagation;
`ifdef IF_MISALIGN_TRAP_EN
    t = tgt; mis_t = wb && (tgt[1:0] != 2'b00);
`else
    t = {tgt[31:2], 2'b00}; mis_t = 1'b0;
`endif
    exp_rv = (n_out < MAXO) &&
      (wb || (expq.size() + n_live < DEPTH)) &&
      (wb ? !mis_t : !halted_m);
    check("req_valid", s_req_valid, exp_rv);
    check("if_valid", if_valid, expq.size() != 0);
    if (dut.iq_push) check("iq_no_overflow", dut.iq_count < DEPTH, 1);
    if (wb) begin
      epoch++;
      expq.delete();
      halted_m = mis_t;
      if (mis_t) expq.push_back('{t, 32'h0, 1'b1});
    end else if (if_valid && idr && expq.size() > 0) begin
      e = expq.pop_front();
      check("head_pc", pc_propagation, e.pc);
      check("head_instr", instr_out, e.instr);
`ifdef IF_MISALIGN_TRAP_EN
      check("head_misalign", if_misalign, e.mis);
`endif
      last_pc = e.pc;
      pops++;
      if (first_val < 0) first_val = cyc;
    end
    if (rv && m.ep == epoch) expq.push_back('{m.addr, m.data, 1'b0});
    if (s_req_valid && rr) begin
      check("req_addr", s_req_addr, wb ? t : exp_next);
      memq.push_back('{s_req_addr, ~s_req_addr, cyc + lat, epoch});
      exp_next = s_req_addr + 32'd4;
      if (first_acc < 0) first_acc = cyc;
    end else if (wb) begin
      exp_next = t;
    end
  endtask

  initial begin : main
    int found;
    // Streaming after reset, L=1
    do_reset();
    lat = 1;
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    check("first_latency", first_val - first_acc, 2);
    pops = 0;
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    check("throughput", pops, 10);

    // Decode stall fills exactly DEPTH entries
    do_reset();
    repeat (20) step(1'b0, '0, 1'b1, 1'b0);
    check("stall_req_valid", s_req_valid, 0);
    check("stall_count", dut.iq_count, DEPTH);
    repeat (6) step(1'b0, '0, 1'b0, 1'b1);
    check("drain_hold_pc", pc_propagation, 32'hC);
    check("drain_if_valid", if_valid, 0);

    // Redirect with two stale requests in flight, L=3
    do_reset();
    lat = 3;
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (s_if_valid) begin
        found = 1;
        check("redir_first_pc", s_pc, 32'h100);
      end
    end
    if (found == 0) check("redir_timeout", 0, 1);

    // Redirect coinciding with a response and a pop
    do_reset();
    lat = 1;
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("flush_no_valid", s_if_valid, 0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("flush_new_valid", s_if_valid, 1);
    check("flush_new_pc", s_pc, 32'h200);

    // Memory not ready, then redirect
    repeat (5) step(1'b0, '0, 1'b0, 1'b1);
    check("hold_last_pc", pc_propagation, last_pc);
    step(1'b1, 32'h40, 1'b1, 1'b1);
    check("redir_req_valid", s_req_valid, 1);
    check("redir_req_addr", s_req_addr, 32'h40);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // PC wraps modulo 2^32
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("pc_wrap", s_req_addr, 32'h0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

`ifdef IF_MISALIGN_TRAP_EN
    step(1'b1, 32'h102, 1'b1, 1'b1);
    check("mis_no_req", s_req_valid, 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("mis_valid", s_if_valid, 1);
    check("mis_pc", s_pc, 32'h102);
    check("mis_flag", if_misalign, 1);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    check("mis_halted", s_req_valid, 0);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    check("mis_resume", s_req_addr, 32'h300);
`else
    step(1'b1, 32'h102, 1'b1, 1'b1);
    check("align_force", s_req_addr, 32'h100);
`endif
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // Random traffic with a mid-run reset
    lat = 2;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 19) == 0,
           $urandom_range(0, 255) << 2 |
             (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0);
    end
    repeat (12) step(1'b0, '0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
